// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: async-FIFO read drain with 2-entry skid and flush; traffic counters when FIFO_DRAIN_STATS_EN is defined
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8
`ifdef FIFO_DRAIN_STATS_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  drain_en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef FIFO_DRAIN_STATS_EN
  , output logic [CNT_WIDTH-1:0] words_out
  , output logic [CNT_WIDTH-1:0] words_flushed
  , output logic [CNT_WIDTH-1:0] stall_cycles
`endif
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2;
  logic [1:0] state_q, state_d, occ_q, occ_d, base;
  logic inflight_q, inflight_d, pop, push;
  logic [DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d, shifted;
  // Handshake, credit-gated read issue (a pop this cycle frees a slot) and busy
  always_comb begin
    m_valid = (occ_q != 2'd0) && (state_q != FLUSH);
    pop = m_valid && m_ready;
    push = inflight_q && (state_q != FLUSH) && !flush;
    fifo_r_en = (state_q == RUN) && !flush && !fifo_empty &&
                (({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
    busy = (state_q != IDLE) || (occ_q != 2'd0) || inflight_q;
    m_data = e0_q;
  end
  // Skid shift/insert, occupancy, in-flight tracking and state transitions
  always_comb begin
    base = occ_q - {1'b0, pop};
    shifted = pop ? e1_q : e0_q;
    e0_d = (push && base == 2'd0) ? fifo_data : shifted;
    e1_d = (push && base == 2'd1) ? fifo_data : e1_q;
    occ_d = flush ? 2'd0 : occ_q + {1'b0, push} - {1'b0, pop};
    inflight_d = fifo_r_en;
    state_d = flush ? FLUSH :
              (state_q == FLUSH) ? ((!inflight_q && occ_q == 2'd0) ? IDLE : FLUSH) :
              drain_en ? RUN : IDLE;
  end
  // State, occupancy and skid registers
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= IDLE;
      occ_q <= 2'd0;
      inflight_q <= 1'b0;
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      state_q <= state_d;
      occ_q <= occ_d;
      inflight_q <= inflight_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end
`ifdef FIFO_DRAIN_STATS_EN
  logic [CNT_WIDTH-1:0] words_out_q, words_out_d, words_flushed_q, words_flushed_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  // Discards on flush are the words left after any same-cycle pop plus the in-flight word
  always_comb begin
    words_out_d = words_out_q + CNT_WIDTH'(pop);
    words_flushed_d = words_flushed_q +
      (flush ? CNT_WIDTH'(occ_q - {1'b0, pop}) + CNT_WIDTH'(inflight_q) :
       (state_q == FLUSH) ? CNT_WIDTH'(inflight_q) : '0);
    stall_cycles_d = stall_cycles_q + CNT_WIDTH'(m_valid && !m_ready);
  end
  // Wrapping statistic counters
  always_ff @(posedge rclk) begin
    if (rrst) begin
      words_out_q <= '0;
      words_flushed_q <= '0;
      stall_cycles_q <= '0;
    end else begin
      words_out_q <= words_out_d;
      words_flushed_q <= words_flushed_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  assign words_out = words_out_q;
  assign words_flushed = words_flushed_q;
  assign stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: directed vector table plus hand sequences for fifo_rd_drain
module tb_fifo_rd_drain;
  typedef struct {
    logic de, mr, ren, v;
    logic [7:0] d;
    logic b;
  } vec_t;
  logic rclk = 1'b0, rrst = 1'b1, drain_en = 1'b0, flush = 1'b0, m_ready = 1'b0;
  logic fifo_empty, fifo_r_en, m_valid, busy;
  logic [7:0] fifo_data, m_data;
  logic [7:0] fmem [0:63];
  int fr, fw, n_chk, n_fail;
  vec_t vecs [11];
`ifdef FIFO_DRAIN_STATS_EN
  logic [31:0] words_out, words_flushed, stall_cycles;
`endif
  fifo_rd_drain dut (
    .rclk(rclk), .rrst(rrst), .drain_en(drain_en), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_r_en(fifo_r_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
`ifdef FIFO_DRAIN_STATS_EN
    , .words_out(words_out), .words_flushed(words_flushed), .stall_cycles(stall_cycles)
`endif
  );
  always #5 rclk = ~rclk;
  // FIFO model: registered read data, pointers unaffected by rrst
  assign fifo_empty = (fr == fw);
  always @(posedge rclk) if (fifo_r_en) begin
    fifo_data <= fmem[fr];
    fr <= fr + 1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    int first_re, first_v, idx, nr, nv;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    for (int i = 0; i < 5; i++) fmem[i] = 8'(i + 1);
    fw = 5;
    for (int i = 0; i < 2; i++) begin
      @(negedge rclk); #1;
      chk("rst r_en", {31'd0, fifo_r_en}, 0);
      chk("rst m_valid", {31'd0, m_valid}, 0);
      chk("rst busy", {31'd0, busy}, 0);
    end
    chk("rst m_data", {24'd0, m_data}, 0);
`ifdef FIFO_DRAIN_STATS_EN
    chk("rst words_out", words_out, 0);
`endif
    for (int i = 0; i < 11; i++) begin
      @(negedge rclk);
      rrst = 1'b0; drain_en = vecs[i].de; m_ready = vecs[i].mr;
      #1;
      chk($sformatf("row%0d r_en", i), {31'd0, fifo_r_en}, {31'd0, vecs[i].ren});
      chk($sformatf("row%0d m_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].v});
      chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].b});
      if (vecs[i].v) chk($sformatf("row%0d m_data", i), {24'd0, m_data}, {24'd0, vecs[i].d});
    end
    @(negedge rclk);
    for (int i = 0; i < 16; i++) fmem[fw + i] = 8'(i + 1);
    fw += 16; drain_en = 1'b1; m_ready = 1'b1;
    first_re = -1; first_v = -1; idx = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (fifo_r_en && first_re < 0) first_re = c;
      if (m_valid) begin
        if (first_v < 0) first_v = c;
        chk("stream data", {24'd0, m_data}, 32'(idx + 1));
        chk("stream gap", 32'(c), 32'(first_v + idx));
        idx++;
      end
      @(negedge rclk);
    end
    chk("stream count", 32'(idx), 16);
    chk("stream latency", 32'(first_v - first_re), 2);
    drain_en = 1'b0;
    @(negedge rclk); #1;
    chk("stream idle busy", {31'd0, busy}, 0);
    @(negedge rclk);
    fmem[fw] = 8'hA5; fw++; drain_en = 1'b1; m_ready = 1'b1; nr = 0; nv = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (fifo_r_en) nr++;
      if (m_valid) begin
        nv++;
        chk("empty data", {24'd0, m_data}, 32'h A5);
      end
      @(negedge rclk);
    end
    chk("empty reads", 32'(nr), 1);
    chk("empty beats", 32'(nv), 1);
    drain_en = 1'b0;
    @(negedge rclk);
    for (int i = 0; i < 8; i++) fmem[fw + i] = 8'(8'h30 + i);
    fw += 8; drain_en = 1'b1; m_ready = 1'b0;
    repeat (3) @(negedge rclk);
    flush = 1'b1; #1;
    chk("flush1 pre valid", {31'd0, m_valid}, 1);
    chk("flush1 r_en", {31'd0, fifo_r_en}, 0);
    @(negedge rclk);
    flush = 1'b0; drain_en = 1'b0; #1;
    chk("flush1 m_valid", {31'd0, m_valid}, 0);
    chk("flush1 busy", {31'd0, busy}, 1);
    chk("flush1 r_en idle", {31'd0, fifo_r_en}, 0);
    @(negedge rclk); #1;
    chk("flush1 busy done", {31'd0, busy}, 0);
`ifdef FIFO_DRAIN_STATS_EN
    chk("flush1 words_flushed", words_flushed, 2);
`endif
    @(negedge rclk);
    drain_en = 1'b1; m_ready = 1'b1;
    repeat (2) @(negedge rclk);
    #1;
    chk("flush2 r_en before", {31'd0, fifo_r_en}, 1);
    @(negedge rclk);
    flush = 1'b1; #1;
    chk("flush2 forced r_en", {31'd0, fifo_r_en}, 0);
    @(negedge rclk);
    flush = 1'b0; drain_en = 1'b0; #1;
    chk("flush2 m_valid", {31'd0, m_valid}, 0);
    @(negedge rclk); #1;
    chk("flush2 busy done", {31'd0, busy}, 0);
    @(negedge rclk);
    drain_en = 1'b1; m_ready = 1'b0;
    repeat (4) @(negedge rclk);
    #1;
    chk("rstmid pre valid", {31'd0, m_valid}, 1);
    chk("rstmid pre data", {24'd0, m_data}, 32'h34);
    rrst = 1'b1;
    @(negedge rclk);
    rrst = 1'b0; drain_en = 1'b0; #1;
    chk("rstmid m_valid", {31'd0, m_valid}, 0);
    chk("rstmid r_en", {31'd0, fifo_r_en}, 0);
    chk("rstmid busy", {31'd0, busy}, 0);
    chk("rstmid m_data", {24'd0, m_data}, 0);
`ifdef FIFO_DRAIN_STATS_EN
    chk("rstmid words_flushed", words_flushed, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
